pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_slot.sv | 34 +++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage state encoding, default payload width and
// a helper mapping a stage state to its held-entry count.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_count(input pipe_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Skid slot of the pipeline stage: one payload register plus its valid bit.
// Clear wins over load so a flush can never leave a stale entry behind.
module pipe_skid_slot #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Valid bit: set on load, dropped on clear or reset.
  always_ff @(posedge clk) begin
    if (reset || i_clear) r_valid <= 1'b0;
    else if (i_load)      r_valid <= 1'b1;
  end

  // Payload register: only rewritten on load, never cleared by a flush.
  always_ff @(posedge clk) begin
    if (reset)       r_data <= RESET_DATA;
    else if (i_load) r_data <= i_data;
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register (e.g. IF/ID PC + instruction).
// Build option PIPE_STAGE_SKID_EN: adds a skid slot so in_ready comes from
// the state flop (no path from out_ready). Without it the stage holds a
// single entry and in_ready = !out_valid || out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] w_main_src;
  logic              w_accept;
  logic              w_release;
  logic              w_main_load;

`ifdef PIPE_STAGE_SKID_EN
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;

  pipe_skid_slot #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  // Registered ready: depends only on the state flop (gated during reset).
  assign in_ready   = (r_state != ST_FULL) && !reset;
  // A release from FULL refills main from the skid slot, otherwise from input.
  assign w_main_src = w_skid_valid ? w_skid_data : in_data;
`else
  // Single-slot build: pass-through ready keeps full throughput.
  assign in_ready   = (!out_valid || out_ready) && !reset;
  assign w_main_src = in_data;
`endif

  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main_data;
  assign count     = state_count(r_state);

  // Next-state and slot control; flush overrides any accept/release.
  always_comb begin
    w_accept    = in_valid && in_ready;
    w_release   = out_valid && out_ready;
    w_state_nxt = r_state;
    w_main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_clear = 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_release) begin
            w_main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_skid_load = 1'b1;
`endif
          end else if (w_release) begin
            w_state_nxt = ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (w_release) begin
            w_state_nxt  = ST_ONE;
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
          end
        end
`endif
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Main slot payload; holds its value when idle, flushed or drained.
  always_ff @(posedge clk) begin
    if (reset)            r_main_data <= RESET_DATA;
    else if (w_main_load) r_main_data <= w_main_src;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed reset/stream/stall/flush scenarios
// then random traffic, all compared against a bounded FIFO queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  count;

  pipe_stage_reg #(.DATA_W(64), .RESET_DATA(64'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] q[$];
  logic [63:0] last_out;
  logic        known;
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cyc(input logic rst, input logic fl, input logic iv,
                     input logic ord, input logic [63:0] d);
    logic exp_ir;
    logic rel;
    reset = rst; flush = fl; in_valid = iv; out_ready = ord; in_data = d;
    if (rst)           exp_ir = 1'b0;
    else if (CAP == 2) exp_ir = (q.size() < 2);
    else               exp_ir = (q.size() == 0) || ord;
    #2;
    chk("in_ready", in_ready, exp_ir);
    if (known) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("count", count, q.size());
      chk("out_data", out_data, (q.size() != 0) ? q[0] : last_out);
    end
`ifdef PIPE_STAGE_SKID_EN
    if (!rst) begin
      out_ready = ~ord;
      #1;
      chk("in_ready_indep", in_ready, exp_ir);
      out_ready = ord;
    end
`endif
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      last_out = 64'd0;
    end else if (fl) begin
      q.delete();
    end else begin
      rel = (q.size() != 0) && ord;
      if (rel) void'(q.pop_front());
      if (iv && exp_ir) begin
        q.push_back(d);
        last_acc = 1'b1;
      end
    end
    if (q.size() != 0) last_out = q[0];
    if (q.size() > CAP) chk("model_cap", q.size(), CAP);
    @(posedge clk);
    #1;
    known = 1'b1;
  endtask

  logic        c_done;
  logic [63:0] stream_vals[3];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    known = 1'b0; last_acc = 1'b0; last_out = 64'd0;
    stream_vals[0] = 64'h1000_0013;
    stream_vals[1] = 64'h1004_0093;
    stream_vals[2] = 64'h1008_0113;

    // Reset two cycles with a live input offered.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 64'hDEAD);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 64'hBEEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    // Back-to-back streaming.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, stream_vals[i]);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    // Stall with A, B, C offered, then drain.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'hA);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'hB);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'hC);
    c_done = 1'b0;
    for (int k = 0; k < 4 && !c_done; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'hC);
      c_done = last_acc;
    end
    chk("c_accepted", c_done, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    // Fill, then flush with D offered.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h12);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'hD);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 10000; n++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 6),
          {$urandom, $urandom});
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
